ms_riscv32_mp_wb_stage: RTL and testbench

Writeback stage that drives the write side of the integer register file: wr_en, rd_addr and rd data.
- Registers the MEM-stage result bundle into a one-entry MEM/WB pipeline register.
- Aligns and extends synchronous data-memory load data that returns one cycle after the request.
- Selects the writeback source.
- Counts retired instructions.

---
 rtl/ms_riscv32_mp_pkg.sv | 17 +
 rtl/ms_riscv32_mp_load_align.sv | 39 +++
 rtl/ms_riscv32_mp_wb_stage.sv | 150 +++++++++++++++
 tb/tb_ms_riscv32_mp_wb_stage.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ms_riscv32_mp_pkg.sv
// Shared encodings for the ms_riscv32_mp pipeline: writeback source select
// and load access size.
package ms_riscv32_mp_pkg;

   // Writeback source select (wb_sel); codes 5..7 are reserved and write 0.
   localparam logic [2:0] WB_ALU  = 3'd0;
   localparam logic [2:0] WB_LOAD = 3'd1;
   localparam logic [2:0] WB_PC4  = 3'd2;
   localparam logic [2:0] WB_CSR  = 3'd3;
   localparam logic [2:0] WB_IMM  = 3'd4;

   // Load access size; code 3 behaves as a word access.
   localparam logic [1:0] LS_BYTE = 2'd0;
   localparam logic [1:0] LS_HALF = 2'd1;
   localparam logic [1:0] LS_WORD = 2'd2;

endpackage

// File: rtl/ms_riscv32_mp_load_align.sv
// Load data aligner: picks the addressed byte/half out of the 32-bit memory
// word and sign- or zero-extends it. Purely combinational.
module ms_riscv32_mp_load_align
   import ms_riscv32_mp_pkg::*;
(
   input  logic [31:0] dmdata_in,
   input  logic [1:0]  lsb_in,
   input  logic [1:0]  size_in,
   input  logic        unsigned_in,
   output logic [31:0] load_data_out
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Lane selection; half-word lsb[0] is ignored because misaligned
   // accesses are trapped before they reach this stage.
   always_comb begin
      byte_sel = dmdata_in[7:0];
      case (lsb_in)
         2'd0:    byte_sel = dmdata_in[7:0];
         2'd1:    byte_sel = dmdata_in[15:8];
         2'd2:    byte_sel = dmdata_in[23:16];
         default: byte_sel = dmdata_in[31:24];
      endcase
      half_sel = lsb_in[1] ? dmdata_in[31:16] : dmdata_in[15:0];
   end

   // Extension by access size; word (and code 3) pass straight through.
   always_comb begin
      load_data_out = dmdata_in;
      case (size_in)
         LS_BYTE: load_data_out = {{24{~unsigned_in & byte_sel[7]}}, byte_sel};
         LS_HALF: load_data_out = {{16{~unsigned_in & half_sel[15]}}, half_sel};
         default: load_data_out = dmdata_in;
      endcase
   end

endmodule

// File: rtl/ms_riscv32_mp_wb_stage.sv
// Writeback stage: one-entry MEM/WB register, load alignment, writeback
// source mux, register-file write port and retired-instruction counter.
//
// Handshake: valid_in qualifies the MEM bundle at a rising edge. flush_in
// kills that capture (highest priority); otherwise stall_in holds every
// MEM/WB field and also suppresses the write and the retire of the held
// instruction. With neither asserted the bundle is taken unconditionally.
module ms_riscv32_mp_wb_stage
   import ms_riscv32_mp_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 64
)
(
   input  logic              ms_riscv32_mp_clk_in,
   input  logic              ms_riscv32_mp_rst_in,
   input  logic              valid_in,
   input  logic              stall_in,
   input  logic              flush_in,
   input  logic              rf_wr_en_in,
   input  logic [4:0]        rd_addr_in,
   input  logic [2:0]        wb_sel_in,
   input  logic [DATA_W-1:0] alu_result_in,
   input  logic [DATA_W-1:0] pc_plus4_in,
   input  logic [DATA_W-1:0] csr_data_in,
   input  logic [DATA_W-1:0] imm_in,
   input  logic [1:0]        load_size_in,
   input  logic              load_unsigned_in,
   input  logic [1:0]        daddr_lsb_in,
   input  logic [DATA_W-1:0] dmdata_in,
   output logic              wr_en_out,
   output logic [4:0]        rd_addr_out,
   output logic [DATA_W-1:0] rd_out,
   output logic [CNT_W-1:0]  instret_out
);

   logic              valid_q,         valid_d;
   logic              rf_wr_en_q,      rf_wr_en_d;
   logic [4:0]        rd_addr_q,       rd_addr_d;
   logic [2:0]        wb_sel_q,        wb_sel_d;
   logic [DATA_W-1:0] alu_q,           alu_d;
   logic [DATA_W-1:0] pc_plus4_q,      pc_plus4_d;
   logic [DATA_W-1:0] csr_q,           csr_d;
   logic [DATA_W-1:0] imm_q,           imm_d;
   logic [1:0]        load_size_q,     load_size_d;
   logic              load_unsigned_q, load_unsigned_d;
   logic [1:0]        daddr_lsb_q,     daddr_lsb_d;
   logic [CNT_W-1:0]  instret_q,       instret_d;

   logic              retire;
   logic [31:0]       load_data;

   // An instruction retires when it sits valid in WB and is not stalled;
   // flush only affects what is captured behind it.
   assign retire = valid_q & ~stall_in;

   // MEM/WB capture: flush kills, stall holds, otherwise load the bundle.
   always_comb begin
      valid_d         = valid_q;
      rf_wr_en_d      = rf_wr_en_q;
      rd_addr_d       = rd_addr_q;
      wb_sel_d        = wb_sel_q;
      alu_d           = alu_q;
      pc_plus4_d      = pc_plus4_q;
      csr_d           = csr_q;
      imm_d           = imm_q;
      load_size_d     = load_size_q;
      load_unsigned_d = load_unsigned_q;
      daddr_lsb_d     = daddr_lsb_q;
      if (flush_in) begin
         valid_d = 1'b0;
      end else if (!stall_in) begin
         valid_d         = valid_in;
         rf_wr_en_d      = rf_wr_en_in;
         rd_addr_d       = rd_addr_in;
         wb_sel_d        = wb_sel_in;
         alu_d           = alu_result_in;
         pc_plus4_d      = pc_plus4_in;
         csr_d           = csr_data_in;
         imm_d           = imm_in;
         load_size_d     = load_size_in;
         load_unsigned_d = load_unsigned_in;
         daddr_lsb_d     = daddr_lsb_in;
      end
   end

   // Retired-instruction counter, wraps naturally at 2^CNT_W.
   always_comb begin
      instret_d = instret_q + {{(CNT_W-1){1'b0}}, retire};
   end

   // State registers with asynchronous active-high reset.
   always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
      if (ms_riscv32_mp_rst_in) begin
         valid_q         <= 1'b0;
         rf_wr_en_q      <= 1'b0;
         rd_addr_q       <= '0;
         wb_sel_q        <= '0;
         alu_q           <= '0;
         pc_plus4_q      <= '0;
         csr_q           <= '0;
         imm_q           <= '0;
         load_size_q     <= '0;
         load_unsigned_q <= 1'b0;
         daddr_lsb_q     <= '0;
         instret_q       <= '0;
      end else begin
         valid_q         <= valid_d;
         rf_wr_en_q      <= rf_wr_en_d;
         rd_addr_q       <= rd_addr_d;
         wb_sel_q        <= wb_sel_d;
         alu_q           <= alu_d;
         pc_plus4_q      <= pc_plus4_d;
         csr_q           <= csr_d;
         imm_q           <= imm_d;
         load_size_q     <= load_size_d;
         load_unsigned_q <= load_unsigned_d;
         daddr_lsb_q     <= daddr_lsb_d;
         instret_q       <= instret_d;
      end
   end

   // Memory data arrives the cycle after capture, so it is aligned live
   // against the registered size/sign/lsb rather than being registered.
   ms_riscv32_mp_load_align u_load_align (
      .dmdata_in     (dmdata_in),
      .lsb_in        (daddr_lsb_q),
      .size_in       (load_size_q),
      .unsigned_in   (load_unsigned_q),
      .load_data_out (load_data)
   );

   // Writeback source mux; reserved select codes write zero.
   always_comb begin
      rd_out = '0;
      case (wb_sel_q)
         WB_ALU:  rd_out = alu_q;
         WB_LOAD: rd_out = load_data;
         WB_PC4:  rd_out = pc_plus4_q;
         WB_CSR:  rd_out = csr_q;
         WB_IMM:  rd_out = imm_q;
         default: rd_out = '0;
      endcase
   end

   assign wr_en_out   = retire & rf_wr_en_q & (rd_addr_q != 5'd0);
   assign rd_addr_out = rd_addr_q;
   assign instret_out = instret_q;

endmodule

// File: tb/tb_ms_riscv32_mp_wb_stage.sv
// Testbench for ms_riscv32_mp_wb_stage: vector table through a scoreboard,
// then hand-written stall / flush / reset sequences.
module tb_ms_riscv32_mp_wb_stage;
   import ms_riscv32_mp_pkg::*;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   always #5 clk = ~clk;

   logic        valid_in = 0, stall_in = 0, flush_in = 0, rf_wr_en_in = 0;
   logic [4:0]  rd_addr_in = 0;
   logic [2:0]  wb_sel_in = 0;
   logic [31:0] alu_result_in = 0, pc_plus4_in = 0, csr_data_in = 0, imm_in = 0;
   logic [1:0]  load_size_in = 0, daddr_lsb_in = 0;
   logic        load_unsigned_in = 0;
   logic [31:0] dmdata_in = 0;
   logic        wr_en_out;
   logic [4:0]  rd_addr_out;
   logic [31:0] rd_out;
   logic [63:0] instret_out;

   ms_riscv32_mp_wb_stage #(.DATA_W(32), .CNT_W(64)) dut (
      .ms_riscv32_mp_clk_in (clk),
      .ms_riscv32_mp_rst_in (rst),
      .valid_in             (valid_in),
      .stall_in             (stall_in),
      .flush_in             (flush_in),
      .rf_wr_en_in          (rf_wr_en_in),
      .rd_addr_in           (rd_addr_in),
      .wb_sel_in            (wb_sel_in),
      .alu_result_in        (alu_result_in),
      .pc_plus4_in          (pc_plus4_in),
      .csr_data_in          (csr_data_in),
      .imm_in               (imm_in),
      .load_size_in         (load_size_in),
      .load_unsigned_in     (load_unsigned_in),
      .daddr_lsb_in         (daddr_lsb_in),
      .dmdata_in            (dmdata_in),
      .wr_en_out            (wr_en_out),
      .rd_addr_out          (rd_addr_out),
      .rd_out               (rd_out),
      .instret_out          (instret_out)
   );

   // ---------------- scoreboard ----------------
   int          checks   = 0;
   int          failures = 0;
   logic [63:0] exp_instret = 0;
   logic [37:0] exp_q[$];   // {wr_en, rd_addr, rd}

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", name, got, exp);
      end
   endtask

   typedef struct {
      logic        valid;
      logic        rf_wr_en;
      logic [4:0]  rd;
      logic [2:0]  sel;
      logic [31:0] alu;
      logic [31:0] pc4;
      logic [31:0] csr;
      logic [31:0] imm;
      logic [1:0]  size;
      logic        uns;
      logic [1:0]  lsb;
      logic        exp_wr_en;
      logic [31:0] exp_rd;
   } vec_t;

   localparam int NV = 19;
   localparam logic [31:0] DM = 32'h80F17F8E;
   vec_t vec[NV];

   task automatic drive_idle();
      valid_in = 0; stall_in = 0; flush_in = 0; rf_wr_en_in = 0;
      rd_addr_in = 0; wb_sel_in = 0; alu_result_in = 0; pc_plus4_in = 0;
      csr_data_in = 0; imm_in = 0; load_size_in = 0; load_unsigned_in = 0;
      daddr_lsb_in = 0;
   endtask

   task automatic drive_instr(input logic v, input logic we, input logic [4:0] rd,
                              input logic [2:0] sel, input logic [31:0] alu,
                              input logic [31:0] pc4, input logic [31:0] csr,
                              input logic [31:0] imm, input logic [1:0] sz,
                              input logic uns, input logic [1:0] lsb);
      valid_in = v; rf_wr_en_in = we; rd_addr_in = rd; wb_sel_in = sel;
      alu_result_in = alu; pc_plus4_in = pc4; csr_data_in = csr; imm_in = imm;
      load_size_in = sz; load_unsigned_in = uns; daddr_lsb_in = lsb;
   endtask

   // Drive one vector at a negedge, push its expectation, capture it, then
   // supply memory data and compare in the following cycle.
   task automatic apply(input vec_t v, input int idx);
      logic [37:0] e;
      drive_instr(v.valid, v.rf_wr_en, v.rd, v.sel, v.alu, v.pc4, v.csr, v.imm,
                  v.size, v.uns, v.lsb);
      exp_q.push_back({v.exp_wr_en, v.rd, v.exp_rd});
      @(posedge clk);
      @(negedge clk);
      drive_idle();
      dmdata_in = DM;
      #1;
      if (exp_q.size() == 0) begin
         checks++; failures++;
         $display("FAIL vec%0d_scoreboard_empty got=0 expected=1", idx);
      end else begin
         e = exp_q.pop_front();
         check($sformatf("vec%0d_wr_en", idx),   {63'd0, wr_en_out},   {63'd0, e[37]});
         check($sformatf("vec%0d_rd_addr", idx), {59'd0, rd_addr_out}, {59'd0, e[36:32]});
         check($sformatf("vec%0d_rd", idx),      {32'd0, rd_out},      {32'd0, e[31:0]});
         check($sformatf("vec%0d_instret", idx), instret_out,          exp_instret);
      end
      @(posedge clk);
      exp_instret = exp_instret + {63'd0, v.valid};
      @(negedge clk);
   endtask

   initial begin
      // valid rf rd sel alu pc4 csr imm size uns lsb -> exp_wr exp_rd
      vec[0]  = '{1, 1, 5'd5,  WB_ALU,  32'hDEADBEEF, 0, 0, 0, LS_WORD, 0, 2'd0, 1, 32'hDEADBEEF};
      vec[1]  = '{1, 1, 5'd6,  WB_LOAD, 32'h11111111, 0, 0, 0, LS_BYTE, 0, 2'd0, 1, 32'hFFFFFF8E};
      vec[2]  = '{1, 1, 5'd7,  WB_LOAD, 32'h11111111, 0, 0, 0, LS_BYTE, 1, 2'd3, 1, 32'h00000080};
      vec[3]  = '{1, 1, 5'd8,  WB_LOAD, 32'h11111111, 0, 0, 0, LS_BYTE, 0, 2'd1, 1, 32'h0000007F};
      vec[4]  = '{1, 1, 5'd9,  WB_LOAD, 32'h11111111, 0, 0, 0, LS_BYTE, 0, 2'd2, 1, 32'hFFFFFFF1};
      vec[5]  = '{1, 1, 5'd10, WB_LOAD, 32'h11111111, 0, 0, 0, LS_HALF, 0, 2'd2, 1, 32'hFFFF80F1};
      vec[6]  = '{1, 1, 5'd11, WB_LOAD, 32'h11111111, 0, 0, 0, LS_HALF, 1, 2'd0, 1, 32'h00007F8E};
      vec[7]  = '{1, 1, 5'd12, WB_LOAD, 32'h11111111, 0, 0, 0, LS_HALF, 0, 2'd3, 1, 32'hFFFF80F1};
      vec[8]  = '{1, 1, 5'd13, WB_LOAD, 32'h11111111, 0, 0, 0, LS_HALF, 1, 2'd2, 1, 32'h000080F1};
      vec[9]  = '{1, 1, 5'd14, WB_LOAD, 32'h11111111, 0, 0, 0, LS_WORD, 0, 2'd0, 1, 32'h80F17F8E};
      vec[10] = '{1, 1, 5'd15, WB_LOAD, 32'h11111111, 0, 0, 0, 2'd3,    1, 2'd1, 1, 32'h80F17F8E};
      vec[11] = '{1, 1, 5'd0,  WB_IMM,  32'h0, 0, 0, 32'h12345000, LS_WORD, 0, 2'd0, 0, 32'h12345000};
      vec[12] = '{1, 1, 5'd16, WB_IMM,  32'h0, 0, 0, 32'hABCDE000, LS_WORD, 0, 2'd0, 1, 32'hABCDE000};
      vec[13] = '{1, 1, 5'd17, WB_CSR,  32'h0, 0, 32'hC0FFEE00, 0, LS_WORD, 0, 2'd0, 1, 32'hC0FFEE00};
      vec[14] = '{1, 1, 5'd18, WB_PC4,  32'h0, 32'h00000104, 0, 0, LS_WORD, 0, 2'd0, 1, 32'h00000104};
      vec[15] = '{1, 1, 5'd19, 3'd5,    32'hFFFFFFFF, 32'h1, 32'h2, 32'h3, LS_WORD, 0, 2'd0, 1, 32'h0};
      vec[16] = '{1, 1, 5'd19, 3'd7,    32'hFFFFFFFF, 32'h1, 32'h2, 32'h3, LS_WORD, 0, 2'd0, 1, 32'h0};
      vec[17] = '{1, 0, 5'd20, WB_ALU,  32'h00001234, 0, 0, 0, LS_WORD, 0, 2'd0, 0, 32'h00001234};
      vec[18] = '{0, 1, 5'd21, WB_ALU,  32'h00005678, 0, 0, 0, LS_WORD, 0, 2'd0, 0, 32'h00005678};

      // ---- reset state ----
      drive_idle();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_wr_en",   {63'd0, wr_en_out},   64'd0);
      check("reset_rd_addr", {59'd0, rd_addr_out}, 64'd0);
      check("reset_rd",      {32'd0, rd_out},      64'd0);
      check("reset_instret", instret_out,          64'd0);
      rst = 1'b0;
      @(negedge clk);

      // ---- table-driven vectors ----
      for (int i = 0; i < NV; i++) apply(vec[i], i);

      // ---- stall 3 cycles with JAL held ----
      drive_instr(1, 1, 5'd1, WB_PC4, 32'h0, 32'h00000104, 0, 0, LS_WORD, 0, 2'd0);
      @(posedge clk);
      @(negedge clk);
      drive_idle();
      stall_in = 1;
      for (int c = 0; c < 3; c++) begin
         #1;
         check($sformatf("stall%0d_wr_en", c), {63'd0, wr_en_out}, 64'd0);
         check($sformatf("stall%0d_instret", c), instret_out, exp_instret);
         @(posedge clk);
         @(negedge clk);
      end
      stall_in = 0;
      #1;
      check("stall_release_wr_en",   {63'd0, wr_en_out},   64'd1);
      check("stall_release_rd_addr", {59'd0, rd_addr_out}, 64'd1);
      check("stall_release_rd",      {32'd0, rd_out},      64'h104);
      @(posedge clk);
      exp_instret = exp_instret + 64'd1;
      @(negedge clk);
      check("stall_after_instret", instret_out, exp_instret);
      check("stall_after_wr_en",   {63'd0, wr_en_out}, 64'd0);

      // ---- flush alone: held instruction still writes and retires ----
      drive_instr(1, 1, 5'd3, WB_ALU, 32'h00000055, 0, 0, 0, LS_WORD, 0, 2'd0);
      @(posedge clk);
      @(negedge clk);
      drive_instr(1, 1, 5'd9, WB_ALU, 32'h00000099, 0, 0, 0, LS_WORD, 0, 2'd0);
      flush_in = 1;
      #1;
      check("flush_held_wr_en", {63'd0, wr_en_out}, 64'd1);
      check("flush_held_rd",    {32'd0, rd_out},    64'h55);
      @(posedge clk);
      exp_instret = exp_instret + 64'd1;
      @(negedge clk);
      drive_idle();
      #1;
      check("flush_killed_wr_en", {63'd0, wr_en_out}, 64'd0);
      check("flush_instret",      instret_out,        exp_instret);
      @(posedge clk);
      @(negedge clk);
      check("flush_killed_no_retire", instret_out, exp_instret);

      // ---- flush and stall together: flush wins, held does not retire ----
      drive_instr(1, 1, 5'd7, WB_ALU, 32'h00000077, 0, 0, 0, LS_WORD, 0, 2'd0);
      @(posedge clk);
      @(negedge clk);
      drive_instr(1, 1, 5'd9, WB_ALU, 32'h00000099, 0, 0, 0, LS_WORD, 0, 2'd0);
      flush_in = 1;
      stall_in = 1;
      #1;
      check("fs_stalled_wr_en", {63'd0, wr_en_out}, 64'd0);
      @(posedge clk);
      @(negedge clk);
      drive_idle();
      #1;
      check("fs_next_wr_en",   {63'd0, wr_en_out}, 64'd0);
      check("fs_next_instret", instret_out,        exp_instret);
      @(posedge clk);
      @(negedge clk);
      check("fs_later_instret", instret_out, exp_instret);

      // ---- reset asserted mid-stream with a valid instruction held ----
      drive_instr(1, 1, 5'd5, WB_ALU, 32'hDEADBEEF, 0, 0, 0, LS_WORD, 0, 2'd0);
      @(posedge clk);
      @(negedge clk);
      drive_idle();
      rst = 1'b1;
      #1;
      check("midrst_wr_en",   {63'd0, wr_en_out}, 64'd0);
      check("midrst_rd",      {32'd0, rd_out},    64'd0);
      check("midrst_instret", instret_out,        64'd0);
      exp_instret = 0;
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         @(negedge clk);
         check($sformatf("idle%0d_wr_en", c), {63'd0, wr_en_out}, 64'd0);
         check($sformatf("idle%0d_instret", c), instret_out, exp_instret);
      end

      if (exp_q.size() != 0) begin
         checks++; failures++;
         $display("FAIL scoreboard_leftover got=%0d expected=0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
